pixel_hinterp_2x: RTL and testbench



---
 rtl/pixel_hinterp_2x_pkg.sv | 21 ++
 rtl/pixel_hinterp_2x_if.sv | 41 ++++
 rtl/pixel_hinterp_2x_avg.sv | 29 ++
 rtl/pixel_hinterp_2x.sv | 115 +++++++++++
 tb/tb_pixel_hinterp_2x.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_hinterp_2x_pkg.sv
// Shared types and defaults for the horizontal 2x interpolator.
// Pixels are packed channel vectors, channel 0 in the LSBs.
package pixel_pkg;

  localparam int CHANNELS_DEF = 3;
  localparam int CH_W_DEF     = 8;
  localparam int PIX_W_DEF    = CHANNELS_DEF * CH_W_DEF;

  typedef enum logic {
    PH_ORIG,
    PH_MID
  } phase_t;

  function automatic int pix_w(
    input int channels,
    input int ch_w
  );
    return channels * ch_w;
  endfunction

endpackage

// File: rtl/pixel_hinterp_2x_if.sv
// Pixel stream bundle around the interpolator: upstream s_* side
// and downstream m_* side, each with valid/ready and a line marker.
interface pixel_hinterp_2x_if
  import pixel_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) ();

  logic [PIX_W-1:0] s_pixel;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;

  logic [PIX_W-1:0] m_pixel;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport slave (
    input  s_pixel,
    input  s_valid,
    input  s_last,
    output s_ready,
    output m_pixel,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport master (
    output s_pixel,
    output s_valid,
    output s_last,
    input  s_ready,
    input  m_pixel,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/pixel_hinterp_2x_avg.sv
// Per-channel average of two packed pixels, truncating or
// rounding half up; channels never carry into each other.
module pixel_average_rnd
  import pixel_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int ROUND    = 0
) (
  input  logic [CHANNELS*CH_W-1:0] a,
  input  logic [CHANNELS*CH_W-1:0] b,
  output logic [CHANNELS*CH_W-1:0] avg
);

  // The +1 bias fits in the extra sum bit, so no overflow.
  localparam logic [CH_W:0] BIAS =
    (CH_W+1)'((ROUND != 0) ? 1 : 0);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CH_W:0] sum;

    // Widen by one bit, add, then drop the LSB.
    assign sum = {1'b0, a[c*CH_W +: CH_W]}
               + {1'b0, b[c*CH_W +: CH_W]}
               + BIAS;
    assign avg[c*CH_W +: CH_W] = CH_W'(sum >> 1);
  end

endmodule

// File: rtl/pixel_hinterp_2x.sv
// Streaming horizontal 2x interpolator: each input pixel is
// followed by its average with the right neighbour (or itself).
module pixel_hinterp_2x
  import pixel_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int CH_W     = CH_W_DEF,
  parameter int ROUND    = 0
) (
  input logic               clk,
  input logic               rst,
  pixel_hinterp_2x_if.slave bus
);

  localparam int PIX_W = pix_w(CHANNELS, CH_W);

  logic [PIX_W-1:0] h_pix;
  logic             h_vld;
  logic             h_last;
  logic [PIX_W-1:0] n_pix;
  logic             n_vld;
  logic             n_last;
  phase_t           phase;

  logic [PIX_W-1:0] avg_pix;
  logic [PIX_W-1:0] m_pix;
  logic             m_vld;
  logic             m_lst;
  logic             is_orig;
  logic             is_dup;
  logic             is_avg;
  logic             s_fire;
  logic             m_fire;
  logic             shift;
  logic             h_free;

  pixel_average_rnd #(
    .CHANNELS (CHANNELS),
    .CH_W     (CH_W),
    .ROUND    (ROUND)
  ) u_avg (
    .a   (h_pix),
    .b   (n_pix),
    .avg (avg_pix)
  );

  assign is_orig = (phase == PH_ORIG);
  assign is_dup  = !is_orig && h_last;
  assign is_avg  = !is_orig && !h_last;

  // Output decode from registers only; no path from m_ready.
  always_comb begin
    m_pix = h_pix;
    m_vld = 1'b0;
    m_lst = 1'b0;
    unique case (1'b1)
      is_orig: m_vld = h_vld;
      is_dup: begin
        m_vld = 1'b1;
        m_lst = 1'b1;
      end
      is_avg: begin
        m_vld = n_vld;
        m_pix = avg_pix;
      end
      default: m_vld = 1'b0;
    endcase
  end

  assign bus.m_pixel = m_pix;
  assign bus.m_valid = m_vld;
  assign bus.m_last  = m_lst;
  assign bus.s_ready = !n_vld;

  assign s_fire = bus.s_valid && !n_vld;
  assign m_fire = m_vld && bus.m_ready;
  assign shift  = m_fire && !is_orig;
  // H is free if the shift empties it or it is already empty.
  assign h_free = shift ? !n_vld : !h_vld;

  // Phase walk, H/N shift, and capture of the incoming pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase  <= PH_ORIG;
      h_pix  <= '0;
      h_vld  <= 1'b0;
      h_last <= 1'b0;
      n_pix  <= '0;
      n_vld  <= 1'b0;
      n_last <= 1'b0;
    end else begin
      if (m_fire) begin
        phase <= is_orig ? PH_MID : PH_ORIG;
      end
      if (shift) begin
        h_pix  <= n_pix;
        h_vld  <= n_vld;
        h_last <= n_last;
        n_vld  <= 1'b0;
      end
      if (s_fire) begin
        if (h_free) begin
          h_pix  <= bus.s_pixel;
          h_vld  <= 1'b1;
          h_last <= bus.s_last;
        end else begin
          n_pix  <= bus.s_pixel;
          n_vld  <= 1'b1;
          n_last <= bus.s_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_hinterp_2x.sv
// Directed bench for pixel_hinterp_2x and its averaging unit.
// Outputs are collected at negedge and compared to hand values.
module tb_pixel_hinterp_2x;
  import pixel_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pixel_hinterp_2x_if #(.PIX_W(24)) bus ();

  pixel_hinterp_2x #(
    .CHANNELS (3),
    .CH_W     (8),
    .ROUND    (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] ua;
  logic [23:0] ub;
  logic [23:0] r0;
  logic [23:0] r1;

  pixel_average_rnd #(.CHANNELS(3), .CH_W(8), .ROUND(0))
    u_r0 (.a(ua), .b(ub), .avg(r0));
  pixel_average_rnd #(.CHANNELS(3), .CH_W(8), .ROUND(1))
    u_r1 (.a(ua), .b(ub), .avg(r1));

  typedef struct {
    logic        last;
    logic [23:0] pix;
    int          cyc;
  } out_t;

  out_t        q[$];
  logic [24:0] expq[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errs = 0;
  logic        mon_en = 1'b0;
  logic        stall_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [24:0] held = '0;

  function automatic logic [23:0] px(int c0, int c1, int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  function automatic logic [23:0] avg_m(logic [23:0] a,
                                        logic [23:0] b);
    logic [23:0] r;
    for (int c = 0; c < 3; c++) begin
      r[c*8 +: 8] = 8'((int'(a[c*8 +: 8])
                      + int'(b[c*8 +: 8])) / 2);
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int idx,
                         input logic [23:0] pix,
                         input logic last);
    if (idx < q.size())
      chk(tag, {q[idx].last, q[idx].pix}, {last, pix});
    else
      chk({tag, "_missing"}, q.size(), idx + 1);
  endtask

  // Called at posedge+1; returns at posedge+1 after the fire edge.
  task automatic push(input logic [23:0] p, input logic l,
                      output int waits);
    bus.s_pixel = p;
    bus.s_valid = 1'b1;
    bus.s_last  = l;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.s_ready) break;
      waits++;
      if (waits > 200) break;
    end
    @(posedge clk);
    #1;
    if (waits > 200) chk("push_timeout", waits, 0);
  endtask

  task automatic idle();
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_q(input string tag, input int n);
    int k;
    k = 0;
    while (q.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    repeat (4) @(negedge clk);
    chk(tag, q.size(), n);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (stall_en) bus.m_ready = 1'($urandom_range(0, 1));
  end

  // Collect fired outputs; check presented data holds in stalls.
  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        vectors++;
        assert ({bus.m_valid, bus.m_last, bus.m_pixel}
                === {1'b1, held}) else begin
          errs++;
          $error("FAIL stall_hold: observed %0h expected %0h",
                 {bus.m_valid, bus.m_last, bus.m_pixel},
                 {1'b1, held});
        end
      end
      if (bus.m_valid && bus.m_ready)
        q.push_back('{bus.m_last, bus.m_pixel, cyc});
      stall_prev <= bus.m_valid && !bus.m_ready;
      held <= {bus.m_last, bus.m_pixel};
    end
  end

  initial begin
    int w;
    logic [23:0] pr[6];
    logic [23:0] p0, p1, p2;

    bus.s_pixel = '0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b1;
    ua = '0;
    ub = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_last",  bus.m_last, 0);
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_m_pixel", bus.m_pixel, 0);
    mon_en = 1'b1;

    // Averaging unit, truncate vs round
    ua = px(1, 255, 0);
    ub = px(2, 255, 1);
    #1;
    chk("avg_trunc_a", r0, px(1, 255, 0));
    chk("avg_round_a", r1, px(2, 255, 1));
    ua = 24'hFFFFFF;
    ub = 24'hFFFFFF;
    #1;
    chk("avg_trunc_ff", r0, 24'hFFFFFF);
    chk("avg_round_ff", r1, 24'hFFFFFF);
    ua = px(3, 0, 254);
    ub = px(4, 1, 255);
    #1;
    chk("avg_trunc_b", r0, px(3, 0, 254));
    chk("avg_round_b", r1, px(4, 1, 255));
    @(posedge clk);
    #1;

    // Three-pixel line
    p0 = px(10, 20, 30);
    p1 = px(100, 0, 255);
    p2 = px(7, 7, 7);
    q.delete();
    push(p0, 1'b0, w);
    chk("lat_m_valid", bus.m_valid, 1);
    chk("lat_m_pixel", bus.m_pixel, p0);
    push(p1, 1'b0, w);
    chk("l3_wait_p1", w <= 1, 1);
    push(p2, 1'b1, w);
    chk("l3_wait_p2", w <= 1, 1);
    idle();
    wait_q("l3_count", 6);
    chk_out("l3_o0", 0, p0, 1'b0);
    chk_out("l3_o1", 1, px(55, 10, 142), 1'b0);
    chk_out("l3_o2", 2, p1, 1'b0);
    chk_out("l3_o3", 3, px(53, 3, 131), 1'b0);
    chk_out("l3_o4", 4, p2, 1'b0);
    chk_out("l3_o5", 5, p2, 1'b1);
    chk("l3_idle", bus.m_valid, 0);

    // Single-pixel line
    q.delete();
    push(px(1, 2, 3), 1'b1, w);
    idle();
    wait_q("l1_count", 2);
    chk_out("l1_o0", 0, px(1, 2, 3), 1'b0);
    chk_out("l1_o1", 1, px(1, 2, 3), 1'b1);
    chk("l1_idle", bus.m_valid, 0);

    // Back-to-back two-pixel lines
    q.delete();
    push(px(0, 0, 0), 1'b0, w);
    push(px(255, 255, 255), 1'b1, w);
    push(px(200, 100, 50), 1'b0, w);
    push(px(201, 101, 51), 1'b1, w);
    idle();
    wait_q("b2b_count", 8);
    chk_out("b2b_o0", 0, px(0, 0, 0), 1'b0);
    chk_out("b2b_o1", 1, px(127, 127, 127), 1'b0);
    chk_out("b2b_o2", 2, px(255, 255, 255), 1'b0);
    chk_out("b2b_o3", 3, px(255, 255, 255), 1'b1);
    chk_out("b2b_o4", 4, px(200, 100, 50), 1'b0);
    chk_out("b2b_o5", 5, px(200, 100, 50), 1'b0);
    chk_out("b2b_o6", 6, px(201, 101, 51), 1'b0);
    chk_out("b2b_o7", 7, px(201, 101, 51), 1'b1);
    if (q.size() == 8)
      chk("b2b_gapless", q[7].cyc - q[0].cyc, 7);

    // Random downstream stalls: five-pixel line then one-pixel line
    q.delete();
    expq.delete();
    for (int i = 0; i < 6; i++)
      pr[i] = px($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      expq.push_back({1'b0, pr[i]});
      if (i < 4) expq.push_back({1'b0, avg_m(pr[i], pr[i+1])});
      else       expq.push_back({1'b1, pr[i]});
    end
    expq.push_back({1'b0, pr[5]});
    expq.push_back({1'b1, pr[5]});
    stall_en = 1'b1;
    for (int i = 0; i < 6; i++)
      push(pr[i], (i == 4) || (i == 5), w);
    idle();
    wait_q("rnd_count", 12);
    stall_en = 1'b0;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      chk_out($sformatf("rnd_o%0d", i), i,
              expq[i][23:0], expq[i][24]);

    // Reset in the middle of a line
    q.delete();
    bus.m_ready = 1'b0;
    push(px(9, 8, 7), 1'b0, w);
    push(px(5, 4, 3), 1'b0, w);
    idle();
    bus.m_ready = 1'b1;
    wait_q("rst_pre_count", 3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_m_valid", bus.m_valid, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    q.delete();
    push(px(40, 50, 60), 1'b1, w);
    idle();
    wait_q("post_rst_count", 2);
    chk_out("post_rst_o0", 0, px(40, 50, 60), 1'b0);
    chk_out("post_rst_o1", 1, px(40, 50, 60), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
